// File: rtl/player_input_pkg.sv
// Shared direction encoding for the player input path and the skeleton decode.
package player_input_pkg;

  localparam int DIR_W    = 3;
  localparam int NUM_DIRS = 4;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_NONE  = 3'd0;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_RIGHT = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_LEFT  = 3'd4;

  // Bit order of per-direction vectors: [0]=up, [1]=right, [2]=down, [3]=left.
  // Returns the highest-priority set direction (up > right > down > left).
  function automatic dir_t pick_dir(input logic [NUM_DIRS-1:0] v);
    dir_t d;
    if (v[0]) begin
      d = DIR_UP;
    end else if (v[1]) begin
      d = DIR_RIGHT;
    end else if (v[2]) begin
      d = DIR_DOWN;
    end else if (v[3]) begin
      d = DIR_LEFT;
    end else begin
      d = DIR_NONE;
    end
    return d;
  endfunction

  // Returns the debounced level belonging to a direction code; none reads as 0.
  function automatic logic dir_held(input logic [NUM_DIRS-1:0] deb, input dir_t code);
    logic h;
    case (code)
      DIR_UP:    h = deb[0];
      DIR_RIGHT: h = deb[1];
      DIR_DOWN:  h = deb[2];
      DIR_LEFT:  h = deb[3];
      default:   h = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for one button.
// The debounced level only follows the synchronised level after it has
// disagreed for DEBOUNCE_CYCLES consecutive samples; any agreeing sample
// restarts the count, so short glitches never reach deb.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreeing samples and commit the new level when stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_r <= 1'b0;
      cnt_r <= '0;
    end else if (sync2_r == deb_r) begin
      deb_r <= deb_r;
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      deb_r <= sync2_r;
      cnt_r <= '0;
    end else begin
      deb_r <= deb_r;
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign deb = deb_r;

endmodule

// File: rtl/player_dir_conditioner.sv
// Conditions one player's four raw direction buttons into a single, mutually
// exclusive direction with "last pressed wins" semantics. A release of the
// selected direction falls back to the highest-priority button still held.
module player_dir_conditioner
  import player_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_up,
  input  logic       raw_right,
  input  logic       raw_down,
  input  logic       raw_left,
  output logic       upSig,
  output logic       rightSig,
  output logic       downSig,
  output logic       leftSig,
  output logic [2:0] dir_code,
  output logic       dir_change
);

  logic [NUM_DIRS-1:0] raw_s;
  logic [NUM_DIRS-1:0] deb_s;
  logic [NUM_DIRS-1:0] deb_d_r;
  logic [NUM_DIRS-1:0] press_s;
  dir_t                cur_r;
  dir_t                next_cur_s;
  logic                change_r;
  logic                up_r;
  logic                right_r;
  logic                down_r;
  logic                left_r;

  assign raw_s = {raw_left, raw_down, raw_right, raw_up};

  for (genvar i = 0; i < NUM_DIRS; i++) begin : gen_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (raw_s[i]),
      .deb   (deb_s[i])
    );
  end

  // Keep last cycle's debounced levels so presses show up as rising edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_d_r <= '0;
    end else begin
      deb_d_r <= deb_s;
    end
  end

  assign press_s = deb_s & ~deb_d_r;

  // Choose the next direction: fresh press first, then release fallback, else hold.
  always_comb begin
    next_cur_s = cur_r;
    if (|press_s) begin
      next_cur_s = pick_dir(press_s);
    end else if ((cur_r != DIR_NONE) && !dir_held(deb_s, cur_r)) begin
      next_cur_s = pick_dir(deb_s);
    end else begin
      next_cur_s = cur_r;
    end
  end

  // Register the selection, its one-hot decode and the change strobe together.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_r    <= DIR_NONE;
      change_r <= 1'b0;
      up_r     <= 1'b0;
      right_r  <= 1'b0;
      down_r   <= 1'b0;
      left_r   <= 1'b0;
    end else begin
      cur_r    <= next_cur_s;
      change_r <= (next_cur_s != cur_r);
      up_r     <= (next_cur_s == DIR_UP);
      right_r  <= (next_cur_s == DIR_RIGHT);
      down_r   <= (next_cur_s == DIR_DOWN);
      left_r   <= (next_cur_s == DIR_LEFT);
    end
  end

  assign dir_code   = cur_r;
  assign dir_change = change_r;
  assign upSig      = up_r;
  assign rightSig   = right_r;
  assign downSig    = down_r;
  assign leftSig    = left_r;

endmodule

// File: tb/tb_player_dir_conditioner.sv
// Bench for player_dir_conditioner with a short debounce window: directed
// scenarios plus randomized button activity, all compared every cycle against
// a behavioural model built from the debounce-window and priority rules.
module tb_player_dir_conditioner;

  localparam int D = 4;

  logic       clock;
  logic       reset;
  logic       raw_up, raw_right, raw_down, raw_left;
  logic       upSig, rightSig, downSig, leftSig;
  logic [2:0] dir_code;
  logic       dir_change;

  int n_checks = 0;
  int n_errors = 0;

  player_dir_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_up     (raw_up),
    .raw_right  (raw_right),
    .raw_down   (raw_down),
    .raw_left   (raw_left),
    .upSig      (upSig),
    .rightSig   (rightSig),
    .downSig    (downSig),
    .leftSig    (leftSig),
    .dir_code   (dir_code),
    .dir_change (dir_change)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Synchronised value = raw as seen two edges earlier (zero after reset).
  // A button's debounced level flips once the last D synchronised samples
  // taken since its previous flip all disagree with it.
  bit [3:0] m_s1, m_s2;
  bit [7:0] m_hist [4];
  int       m_valid [4];
  bit [3:0] m_deb, m_deb_prev;
  int       m_cur;
  bit       m_chg;

  function automatic int first_set(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_edge(input bit rst, input bit [3:0] raw);
    bit [3:0] seen, new_deb, press;
    bit [7:0] win;
    int       nxt;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0;
      m_cur = 0; m_chg = 1'b0;
      for (int i = 0; i < 4; i++) begin m_hist[i] = '0; m_valid[i] = 0; end
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      new_deb = m_deb;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][6:0], seen[i]};
        if (m_valid[i] < 8) m_valid[i]++;
        win = m_hist[i] & 8'((1 << D) - 1);
        if (m_valid[i] >= D && win == (m_deb[i] ? 8'd0 : 8'((1 << D) - 1))) begin
          new_deb[i] = ~m_deb[i];
          m_valid[i] = 0;
        end
      end
      press = m_deb & ~m_deb_prev;
      if (press != 0) nxt = first_set(press);
      else if (m_cur != 0 && !m_deb[m_cur-1]) nxt = first_set(m_deb);
      else nxt = m_cur;
      m_chg = (nxt != m_cur);
      m_cur = nxt;
      m_deb_prev = m_deb;
      m_deb = new_deb;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, step the model on the edge, compare after it.
  task automatic run_cycle(input bit rst, input bit [3:0] raw);
    reset = rst;
    {raw_left, raw_down, raw_right, raw_up} = raw;
    @(posedge clock);
    model_edge(rst, raw);
    #1;
    check("dir_code",   int'(dir_code),   m_cur);
    check("dir_change", int'(dir_change), int'(m_chg));
    check("upSig",      int'(upSig),      int'(m_cur == 1));
    check("rightSig",   int'(rightSig),   int'(m_cur == 2));
    check("downSig",    int'(downSig),    int'(m_cur == 3));
    check("leftSig",    int'(leftSig),    int'(m_cur == 4));
    @(negedge clock);
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 4'b0000);
    run_cycle(1'b1, 4'b0000);
  endtask

  bit [3:0] rnd_raw;

  initial begin
    reset = 1'b1;
    {raw_left, raw_down, raw_right, raw_up} = 4'b0000;
    @(negedge clock);

    // Reset and idle: everything stays at none.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      run_cycle(1'b0, 4'b0000);
      check("idle_code", int'(dir_code), 0);
      check("idle_change", int'(dir_change), 0);
    end

    // Right held from edge 1: selected at edge 7, strobe gone at edge 8.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      run_cycle(1'b0, 4'b0010);
      if (k == 6) check("right_e6_code", int'(dir_code), 0);
      if (k == 7) begin
        check("right_e7_code", int'(dir_code), 2);
        check("right_e7_sig", int'(rightSig), 1);
        check("right_e7_change", int'(dir_change), 1);
      end
      if (k == 8) check("right_e8_change", int'(dir_change), 0);
    end

    // Up glitch of 3 cycles: never reaches the output, counter back to 0.
    do_reset();
    for (int k = 1; k <= 3; k++) run_cycle(1'b0, 4'b0001);
    for (int k = 1; k <= 10; k++) begin
      run_cycle(1'b0, 4'b0000);
      check("glitch_code", int'(dir_code), 0);
    end
    check("glitch_cnt", int'(dut.gen_deb[0].u_deb.cnt_r), 0);

    // Up held, left pressed later overrides, release of left falls back to up.
    do_reset();
    for (int k = 1; k <= 10; k++) run_cycle(1'b0, 4'b0001);
    check("up_held_code", int'(dir_code), 1);
    for (int k = 1; k <= 10; k++) run_cycle(1'b0, 4'b1001);
    check("left_override_code", int'(dir_code), 4);
    for (int k = 1; k <= 7; k++) begin
      run_cycle(1'b0, 4'b0001);
      if (k == 6) check("left_rel_e6_code", int'(dir_code), 4);
      if (k == 7) check("left_rel_e7_code", int'(dir_code), 1);
    end

    // Down and right together: right outranks down; release right gives down.
    do_reset();
    for (int k = 1; k <= 7; k++) run_cycle(1'b0, 4'b0110);
    check("chord_code", int'(dir_code), 2);
    for (int k = 1; k <= 7; k++) run_cycle(1'b0, 4'b0100);
    check("chord_rel_code", int'(dir_code), 3);

    // Up held through a 2-cycle reset: cleared, then re-pressed at edge 7.
    do_reset();
    for (int k = 1; k <= 10; k++) run_cycle(1'b0, 4'b0001);
    check("pre_rst_code", int'(dir_code), 1);
    for (int k = 1; k <= 2; k++) begin
      run_cycle(1'b1, 4'b0001);
      check("in_rst_code", int'(dir_code), 0);
      check("in_rst_change", int'(dir_change), 0);
    end
    for (int k = 1; k <= 7; k++) begin
      run_cycle(1'b0, 4'b0001);
      if (k == 6) check("post_rst_e6_code", int'(dir_code), 0);
      if (k == 7) check("post_rst_e7_code", int'(dir_code), 1);
    end

    // Randomized button activity with occasional resets.
    do_reset();
    rnd_raw = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(5, 0) == 0) rnd_raw[i] = ~rnd_raw[i];
      run_cycle(($urandom_range(299, 0) == 0), rnd_raw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
